packet_picker: RTL

//  Selects the HDMI data-island packet for each packet_enable request from the hdmi core: ACR, AVI InfoFrame
//  (optional), Audio InfoFrame once per video field, then audio sample packets while samples are queued, else null.

---
 rtl/packet_picker_pkg.sv | 26 ++
 rtl/packet_picker_if.sv | 33 +++
 rtl/audio_sample_fifo.sv | 64 ++++++
 rtl/packet_picker.sv | 136 +++++++++++++
 4 files changed

// File: rtl/packet_picker_pkg.sv
// packet_picker_pkg: shared packet-type codes, FSM state type and the IEC 60958
// block-length constant used by the HDMI data-island packet picker.
package packet_picker_pkg;

  localparam logic [7:0] PKT_NULL  = 8'h00;
  localparam logic [7:0] PKT_ACR   = 8'h01;
  localparam logic [7:0] PKT_AUDIO = 8'h02;
  localparam logic [7:0] PKT_AVI   = 8'h82;
  localparam logic [7:0] PKT_AIF   = 8'h84;

  // Frames per IEC 60958 block; frame 0 carries the B (block-start) flag.
  localparam int IEC_FRAMES = 192;

  typedef enum logic [1:0] {
    SEND_ACR,
    SEND_AVI,
    SEND_AIF,
    STREAM
  } picker_state_t;

  // Frame counter successor, wrapping at the end of an IEC block.
  function automatic logic [7:0] next_frame(input logic [7:0] c);
    return (c == 8'(IEC_FRAMES - 1)) ? 8'd0 : c + 8'd1;
  endfunction

endpackage

// File: rtl/packet_picker_if.sv
// packet_picker_if: bundle between the audio source / hdmi core (master) and
// the packet picker (slave).
//   master drives: video_field_end, packet_enable, audio_sample_valid, audio_sample_word
//   slave drives : packet_type, audio_sample_word_packet, audio_sample_word_present,
//                  audio_frame_start, overflow
// Handshake: packet_enable and audio_sample_valid are single-cycle strobes with no
// back-pressure; the picker accepts every strobe. Outputs change only on the
// cycle after a packet_enable and hold until the next one.
interface packet_picker_if #(
  parameter int AW = 16
);
  logic            video_field_end;
  logic            packet_enable;
  logic            audio_sample_valid;
  logic [2*AW-1:0] audio_sample_word;
  logic [7:0]      packet_type;
  logic [8*AW-1:0] audio_sample_word_packet;
  logic [3:0]      audio_sample_word_present;
  logic [3:0]      audio_frame_start;
  logic            overflow;

  modport master (
    output video_field_end, packet_enable, audio_sample_valid, audio_sample_word,
    input  packet_type, audio_sample_word_packet, audio_sample_word_present,
           audio_frame_start, overflow
  );

  modport slave (
    input  video_field_end, packet_enable, audio_sample_valid, audio_sample_word,
    output packet_type, audio_sample_word_packet, audio_sample_word_present,
           audio_frame_start, overflow
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: single-clock FIFO of audio sample pairs with 0..4 pops per
// cycle. The four oldest entries are always visible on rd_data_o (entry 0 in
// the LSBs) so the caller can pack them combinationally before popping.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   wr_valid_i/data  write strobe and sample pair; dropped when full
//   pop_n_i          entries to pop this cycle (caller keeps it <= count_o)
//   count_o          occupancy before this cycle's write/pop
//   rd_data_o        four oldest entries (slots beyond count_o are stale)
//   overflow_o       sticky: a write was dropped on a full FIFO
module audio_sample_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_valid_i,
  input  logic [DW-1:0]                wr_data_i,
  input  logic [2:0]                   pop_n_i,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic [4*DW-1:0]              rd_data_o,
  output logic                         overflow_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          wr_en;

  // Fullness is judged on the pre-cycle count, so a pop in the same cycle
  // does not make room for the incoming sample.
  assign wr_en = wr_valid_i && (count_q < CW'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      rd_ptr_q <= rd_ptr_q + PW'(pop_n_i);
      count_q  <= count_q + CW'(wr_en) - CW'(pop_n_i);
      if (wr_valid_i && !wr_en) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_data_o[i*DW +: DW] = mem_q[rd_ptr_q + PW'(i)];
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/packet_picker.sv
// packet_picker: picks the HDMI data-island packet for each packet_enable:
// ACR, optional AVI InfoFrame, Audio InfoFrame once per video field, then audio
// sample packets (up to 4 queued pairs each) or null packets.
// Build option: define PACKET_PICKER_AVI_INFOFRAME_EN to include the AVI
// InfoFrame (sequence 01, 82, 84, stream); otherwise the sequence is 01, 84, stream.
// Ports:
//   clk_pixel    pixel clock
//   reset        synchronous, active-high
//   bus          packet_picker_if.slave (requests, samples, packet outputs, overflow)
//   dbg_state_o  current FSM state
module packet_picker
  import packet_picker_pkg::*;
#(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic          clk_pixel,
  input  logic          reset,
  packet_picker_if.slave bus,
  output picker_state_t dbg_state_o
);
  localparam int AW = AUDIO_BIT_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  picker_state_t   state_q, state_d, eff_state;
  logic [7:0]      fc_q, fc_d, fc_run;
  logic [7:0]      type_q, type_d;
  logic [8*AW-1:0] payload_q, payload_d;
  logic [3:0]      present_q, present_d;
  logic [3:0]      fs_q, fs_d;
  logic [2:0]      pop_n;
  logic [CW-1:0]   fifo_count;
  logic [8*AW-1:0] fifo_rd_data;
  logic            fifo_overflow;

  audio_sample_fifo #(
    .DW   (2*AW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_pixel),
    .rst_i     (reset),
    .wr_valid_i(bus.audio_sample_valid),
    .wr_data_i (bus.audio_sample_word),
    .pop_n_i   (pop_n),
    .count_o   (fifo_count),
    .rd_data_o (fifo_rd_data),
    .overflow_o(fifo_overflow)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q   <= SEND_ACR;
      fc_q      <= '0;
      type_q    <= PKT_NULL;
      payload_q <= '0;
      present_q <= '0;
      fs_q      <= '0;
    end else begin
      state_q   <= state_d;
      fc_q      <= fc_d;
      type_q    <= type_d;
      payload_q <= payload_d;
      present_q <= present_d;
      fs_q      <= fs_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fc_d      = fc_q;
    fc_run    = fc_q;
    type_d    = type_q;
    payload_d = payload_q;
    present_d = present_q;
    fs_d      = fs_q;
    pop_n     = '0;
    // A field end arriving with a request restarts the sequence before the
    // request is served, so that request yields ACR.
    eff_state = bus.video_field_end ? SEND_ACR : state_q;

    if (bus.packet_enable) begin
      type_d    = PKT_NULL;
      payload_d = '0;
      present_d = '0;
      fs_d      = '0;
      case (eff_state)
        SEND_ACR: begin
          type_d = PKT_ACR;
`ifdef PACKET_PICKER_AVI_INFOFRAME_EN
          state_d = SEND_AVI;
`else
          state_d = SEND_AIF;
`endif
        end
`ifdef PACKET_PICKER_AVI_INFOFRAME_EN
        SEND_AVI: begin
          type_d  = PKT_AVI;
          state_d = SEND_AIF;
        end
`endif
        SEND_AIF: begin
          type_d  = PKT_AIF;
          state_d = STREAM;
        end
        STREAM: begin
          if (fifo_count != '0) begin
            type_d = PKT_AUDIO;
            pop_n  = (fifo_count >= CW'(4)) ? 3'd4 : 3'(fifo_count);
            // Each packed pair takes the next frame number; the block may
            // wrap between sub-packets of one packet.
            for (int i = 0; i < 4; i++) begin
              if (3'(i) < pop_n) begin
                payload_d[i*2*AW +: 2*AW] = fifo_rd_data[i*2*AW +: 2*AW];
                present_d[i]              = 1'b1;
                fs_d[i]                   = (fc_run == 8'd0);
                fc_run                    = next_frame(fc_run);
              end
            end
            fc_d = fc_run;
          end
        end
        default: state_d = SEND_ACR;
      endcase
    end else if (bus.video_field_end) begin
      state_d = SEND_ACR;
    end
  end

  assign bus.packet_type               = type_q;
  assign bus.audio_sample_word_packet  = payload_q;
  assign bus.audio_sample_word_present = present_q;
  assign bus.audio_frame_start         = fs_q;
  assign bus.overflow                  = fifo_overflow;
  assign dbg_state_o                   = state_q;

endmodule
